// File: rtl/mmio_bus_router.sv
// MMIO router: decodes CPU load/store requests onto N slaves by base/mask window and returns one response.
// Optional hung-slave timeout is compiled in when ROUTER_TIMEOUT_EN is defined.
module mmio_bus_router #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h80000000, 32'h70000000, 32'h60000000, 32'h50000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hE0000000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic                         we_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic                         resp_valid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         resp_err_o,
    output logic                         slave_req_o,
    output logic [NUM_SLAVES-1:0]        slave_sel_o,
    output logic [ADDR_W-1:0]            slave_addr_o,
    output logic                         slave_we_o,
    output logic [DATA_W-1:0]            slave_wdata_o,
    input  logic [NUM_SLAVES-1:0]        slave_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slave_rdata_i,
    output logic [ADDR_W-1:0]            err_addr_o,
    output logic [7:0]                   err_cnt_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  we_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [NUM_SLAVES-1:0] sel_reg;
    logic                  unmapped_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  err_reg;
    logic [ADDR_W-1:0]     err_addr_reg;
    logic [7:0]            err_cnt_reg;

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] sel_dec;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_sel;
    logic                  timeout;
    logic                  finish;
    logic                  finish_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
            localparam logic [ADDR_W-1:0] BASE = SLAVE_BASE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] MASK = SLAVE_MASK[gi*ADDR_W +: ADDR_W];
            assign hit[gi] = ((addr_i & MASK) == (BASE & MASK));
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign sel_dec = hit & (~hit + NUM_SLAVES'(1));
    assign ack_sel = |(slave_ack_i & sel_reg);

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_reg[k]) begin
                rdata_sel = rdata_sel | slave_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ROUTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_reg;

    // Counter holds the index of the current ACCESS cycle; fires on the last allowed one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != ACCESS) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // An ack in the same cycle as the timeout takes priority.
                if (unmapped_reg) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (ack_sel) begin
                    finish = 1'b1;
                end else if (timeout) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
                if (finish) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            sel_reg      <= '0;
            unmapped_reg <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid_i) begin
                addr_reg     <= addr_i;
                we_reg       <= we_i;
                wdata_reg    <= wdata_i;
                sel_reg      <= sel_dec;
                unmapped_reg <= ~|sel_dec;
            end
            if (finish) begin
                rdata_reg <= (finish_err || we_reg) ? '0 : rdata_sel;
                err_reg   <= finish_err;
                if (finish_err) begin
                    err_addr_reg <= addr_reg;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign req_ready_o   = (state_reg == IDLE);
    assign resp_valid_o  = (state_reg == RESP);
    assign resp_err_o    = (state_reg == RESP) && err_reg;
    assign rdata_o       = rdata_reg;
    assign slave_req_o   = (state_reg == ACCESS) && !unmapped_reg;
    assign slave_sel_o   = (state_reg == ACCESS) ? sel_reg : '0;
    assign slave_addr_o  = addr_reg;
    assign slave_we_o    = we_reg;
    assign slave_wdata_o = wdata_reg;
    assign err_addr_o    = err_addr_reg;
    assign err_cnt_o     = err_cnt_reg;

endmodule
